// File: rtl/activation_pkg.sv
// Fixed-point types and saturation helpers shared by the activation block and the node.
package activation_pkg;

  typedef logic        [7:0]  q0_8_t;
  typedef logic signed [15:0] q8_8_t;

  // Saturates a signed Q8.8 word into the unsigned range [0, 2**w-1].
  function automatic logic [15:0] clamp_q(input q8_8_t x, input int unsigned w);
    int sx;
    int mx;
    sx = int'(x);
    mx = (1 << w) - 1;
    if (sx < 0)       return '0;
    else if (sx > mx) return mx[15:0];
    else              return x;
  endfunction

  function automatic logic in_range(input q8_8_t x, input int unsigned w);
    int sx;
    int mx;
    sx = int'(x);
    mx = (1 << w) - 1;
    return (sx >= 0) && (sx <= mx);
  endfunction

endpackage

// File: rtl/activation_if.sv
// Argument/result/error/delta streams of the activation block.
interface activation_if #(parameter int unsigned W = 8) ();

  logic          argument_valid;
  logic [15:0]   argument_data;
  logic          argument_ready;

  logic          result_valid;
  logic [W-1:0]  result_data;
  logic          result_ready;

  logic          error_valid;
  logic [15:0]   error_data;
  logic          error_ready;

  logic          delta_valid;
  logic [15:0]   delta_data;
  logic          delta_ready;

  modport master (
    output argument_valid, argument_data, result_ready, error_valid, error_data, delta_ready,
    input  argument_ready, result_valid, result_data, error_ready, delta_valid, delta_data
  );

  modport slave (
    input  argument_valid, argument_data, result_ready, error_valid, error_data, delta_ready,
    output argument_ready, result_valid, result_data, error_ready, delta_valid, delta_data
  );

endinterface

// File: rtl/activation.sv
// Clamped-ReLU activation with optional backward pass gating the error by the forward active flag.
module activation
  import activation_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          train,
  activation_if.slave   bus
);

  typedef enum logic [1:0] {ARG, RES, ERR, DEL} state_t;

  state_t      state,    state_n;
  q8_8_t       arg_q,    arg_n;
  logic        active_q, active_n;
  logic        rv_q,     rv_n;
  logic [15:0] dd_q,     dd_n;
  logic        dv_q,     dv_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ARG;
      arg_q    <= '0;
      active_q <= 1'b0;
      rv_q     <= 1'b0;
      dd_q     <= '0;
      dv_q     <= 1'b0;
    end else begin
      state    <= state_n;
      arg_q    <= arg_n;
      active_q <= active_n;
      rv_q     <= rv_n;
      dd_q     <= dd_n;
      dv_q     <= dv_n;
    end
  end

  always_comb begin
    state_n  = state;
    arg_n    = arg_q;
    active_n = active_q;
    rv_n     = rv_q;
    dd_n     = dd_q;
    dv_n     = dv_q;
    case (state)
      ARG: if (bus.argument_valid) begin
        arg_n    = bus.argument_data;
        active_n = in_range(bus.argument_data, W);
        rv_n     = 1'b1;
        state_n  = RES;
      end
      RES: if (bus.result_ready) begin
        rv_n    = 1'b0;
        state_n = train ? ERR : ARG;
      end
      ERR: if (bus.error_valid) begin
        dd_n    = active_q ? bus.error_data : '0;
        dv_n    = 1'b1;
        state_n = DEL;
      end
      DEL: if (bus.delta_ready) begin
        dv_n    = 1'b0;
        state_n = ARG;
      end
      default: begin
        state_n = ARG;
        $fatal(1, "activation: illegal state %0d", state);
      end
    endcase
  end

  assign bus.argument_ready = (state == ARG);
  assign bus.error_ready    = (state == ERR);
  assign bus.result_valid   = rv_q;
  // Result is a pure function of the registered argument, so it is as stable as a separate register.
  assign bus.result_data    = W'(clamp_q(arg_q, W));
  assign bus.delta_valid    = dv_q;
  assign bus.delta_data     = dd_q;

endmodule

// File: tb/tb_activation.sv
// Directed-vector bench for the activation block.
module tb_activation;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic train = 1'b0;

  int total = 0;
  int bad   = 0;

  activation_if #(.W(8)) bus ();

  activation #(.W(8)) dut (
    .clock (clock),
    .reset (reset),
    .train (train),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic accept_arg(input logic [15:0] a);
    int n;
    n = 0;
    bus.argument_valid = 1'b1;
    bus.argument_data  = a;
    while (!bus.argument_ready && n < 20) begin
      tick();
      n++;
    end
    check("arg_wait", 32'(n < 20), 32'd1);
    tick();
    bus.argument_valid = 1'b0;
  endtask

  task automatic send_err(input logic [15:0] e);
    int n;
    n = 0;
    bus.error_valid = 1'b1;
    bus.error_data  = e;
    while (!bus.error_ready && n < 20) begin
      tick();
      n++;
    end
    check("err_wait", 32'(n < 20), 32'd1);
    tick();
    bus.error_valid = 1'b0;
  endtask

  // Full training transaction; returns after the delta handshake.
  task automatic train_pass(input logic [15:0] a, input logic [15:0] e,
                            input logic [7:0] exp_res, input logic [15:0] exp_delta);
    train = 1'b1;
    bus.result_ready = 1'b1;
    bus.delta_ready  = 1'b0;
    accept_arg(a);
    check("tr_res", 32'(bus.result_data), 32'(exp_res));
    tick();
    check("tr_err_ready", 32'(bus.error_ready), 32'd1);
    send_err(e);
    check("tr_dvalid", 32'(bus.delta_valid), 32'd1);
    check("tr_delta", 32'(bus.delta_data), 32'(exp_delta));
    bus.delta_ready = 1'b1;
    tick();
    check("tr_dclear", 32'(bus.delta_valid), 32'd0);
    check("tr_back_arg", 32'(bus.argument_ready), 32'd1);
    bus.delta_ready = 1'b0;
    train = 1'b0;
  endtask

  logic [15:0] sat_in  [4] = '{16'hFF00, 16'h0100, 16'h00FF, 16'h0000};
  logic [7:0]  sat_exp [4] = '{8'h00,    8'hFF,    8'hFF,    8'h00};

  initial begin
    bus.argument_valid = 1'b0;
    bus.argument_data  = '0;
    bus.result_ready   = 1'b0;
    bus.error_valid    = 1'b0;
    bus.error_data     = '0;
    bus.delta_ready    = 1'b0;

    #1 reset = 1'b0;
    #1;
    check("rst_arg_ready", 32'(bus.argument_ready), 32'd1);
    check("rst_err_ready", 32'(bus.error_ready), 32'd0);
    check("rst_rvalid", 32'(bus.result_valid), 32'd0);
    check("rst_rdata", 32'(bus.result_data), 32'd0);
    check("rst_dvalid", 32'(bus.delta_valid), 32'd0);
    check("rst_ddata", 32'(bus.delta_data), 32'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    tick();
    check("rel_arg_ready", 32'(bus.argument_ready), 32'd1);

    // Inference of 0x0080
    train = 1'b0;
    bus.result_ready = 1'b1;
    accept_arg(16'h0080);
    check("inf_rvalid", 32'(bus.result_valid), 32'd1);
    check("inf_rdata", 32'(bus.result_data), 32'h80);
    check("inf_arg_busy", 32'(bus.argument_ready), 32'd0);
    tick();
    check("inf_rclear", 32'(bus.result_valid), 32'd0);
    check("inf_back_arg", 32'(bus.argument_ready), 32'd1);
    check("inf_no_err", 32'(bus.error_ready), 32'd0);

    // Saturation boundaries
    for (int i = 0; i < 4; i++) begin
      accept_arg(sat_in[i]);
      check($sformatf("sat%0d", i), 32'(bus.result_data), 32'(sat_exp[i]));
      tick();
      check($sformatf("sat%0d_arg", i), 32'(bus.argument_ready), 32'd1);
    end

    // Backward passes: pass-through, blocked, inclusive upper bound, just above
    train_pass(16'h0040, 16'h0123, 8'h40, 16'h0123);
    train_pass(16'h8000, 16'h7FFF, 8'h00, 16'h0000);
    train_pass(16'h00FF, 16'h0456, 8'hFF, 16'h0456);
    train_pass(16'h0100, 16'h0456, 8'hFF, 16'h0000);

    // Argument and train ignored in ERR; delta held under backpressure
    train = 1'b1;
    bus.result_ready = 1'b1;
    accept_arg(16'h0022);
    tick();
    train = 1'b0;
    bus.argument_valid = 1'b1;
    bus.argument_data  = 16'h0011;
    tick();
    bus.argument_valid = 1'b0;
    check("err_hold_state", 32'(bus.error_ready), 32'd1);
    check("err_no_capture", 32'(bus.result_data), 32'h22);
    send_err(16'hABCD);
    tick();
    tick();
    check("del_hold_valid", 32'(bus.delta_valid), 32'd1);
    check("del_hold_data", 32'(bus.delta_data), 32'hABCD);
    bus.delta_ready = 1'b1;
    tick();
    bus.delta_ready = 1'b0;
    check("del_done", 32'(bus.argument_ready), 32'd1);

    // Result backpressure for 5 cycles
    bus.result_ready = 1'b0;
    accept_arg(16'h0033);
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", 32'(bus.result_valid), 32'd1);
      check("bp_rdata", 32'(bus.result_data), 32'h33);
      check("bp_arg_busy", 32'(bus.argument_ready), 32'd0);
      tick();
    end
    bus.result_ready = 1'b1;
    tick();
    check("bp_rclear", 32'(bus.result_valid), 32'd0);
    check("bp_arg_ready", 32'(bus.argument_ready), 32'd1);

    // Reset while in DEL
    train = 1'b1;
    accept_arg(16'h0010);
    tick();
    send_err(16'h0123);
    check("pre_rst_dvalid", 32'(bus.delta_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_del_dvalid", 32'(bus.delta_valid), 32'd0);
    check("rst_del_ddata", 32'(bus.delta_data), 32'd0);
    check("rst_del_arg", 32'(bus.argument_ready), 32'd1);
    @(posedge clock);
    #2 reset = 1'b1;
    tick();
    check("rst_del_rel", 32'(bus.argument_ready), 32'd1);
    train_pass(16'h0200, 16'h1111, 8'hFF, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/activation.md
ACTIVATION -- requirements
Module: activation

Interface
REQ-001 SHALL have parameter W, default 8, meaning width of result_data (fixed-point Q0.W, unsigned).
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port train  input  1  when high at result handshake, run the backward pass.
REQ-005 SHALL have ports argument_valid input 1, argument_data input 16, argument_ready output 1: upstream node product, signed Q8.8.
REQ-006 SHALL have ports result_valid output 1, result_data output W, result_ready input 1: activated value to the next layer operand.
REQ-007 SHALL have ports error_valid input 1, error_data input 16, error_ready output 1: signed Q8.8 error fed back from the next layer.
REQ-008 SHALL have ports delta_valid output 1, delta_data output 16, delta_ready input 1: signed Q8.8 delta to the upstream node.

Function
REQ-009 SHALL implement a state machine with states ARG, RES, ERR, DEL.
REQ-010 SHALL assert argument_ready iff state is ARG, and error_ready iff state is ERR, both as pure state decodes.
REQ-011 In ARG, on argument_valid & argument_ready, SHALL register argument_data and result_data = clamp(argument_data, 0, 2**W-1), set result_valid, and go to RES; result_valid is therefore high one cycle after the accepting edge.
REQ-012 Clamp rule: signed argument < 0 -> 0; argument > 2**W-1 -> 2**W-1; otherwise argument[W-1:0].
REQ-013 SHALL record an active flag at argument accept: 1 iff 0 <= argument <= 2**W-1 (both bounds inclusive), else 0.
REQ-014 In RES, SHALL hold result_valid and result_data stable until result_ready; on handshake SHALL clear result_valid and go to ERR if train is high on that edge, else to ARG.
REQ-015 In ERR, on error_valid & error_ready, SHALL set delta_data = error_data if active flag is 1 else 16'h0000, set delta_valid, and go to DEL.
REQ-016 In DEL, SHALL hold delta_valid and delta_data stable until delta_ready; on handshake SHALL clear delta_valid and go to ARG.
REQ-017 SHALL have no combinational path from any input to any output valid or data; ready outputs depend only on state.
REQ-018 SHALL ignore argument_valid outside ARG and error_valid outside ERR (no data capture, no state change).
REQ-019 Throughput SHALL be one argument per 2 cycles minimum in inference (ARG -> RES -> ARG with result_ready held high).
REQ-020 train SHALL be sampled only at the result handshake edge; changes at other times have no effect.

Reset
REQ-021 On reset low, SHALL immediately (asynchronously) enter ARG, clear result_valid and delta_valid, and zero result_data, delta_data, the registered argument, and the active flag.
REQ-022 Reset asserted mid-transaction (any state) SHALL discard the in-flight argument or error; first post-reset accept behaves as from power-up.
REQ-023 SHALL leave the machine in ARG with argument_ready high on the first edge after reset release.

Structure
REQ-024 Fixed-point typedefs (Q0.8 operand, signed Q8.8 extended word) and the clamp/saturate function SHALL live in a shared package used by both this block and the node.
REQ-025 The state enumeration SHALL be local to this module; an illegal state SHALL raise a simulation fatal error.
REQ-026 No sub-module is required; the block is a single module.

Verification
REQ-027 Inference: train=0, argument 16'h0080, result_ready=1 -> result_data 8'h80 one cycle after accept, return to ARG, no error_ready.
REQ-028 Saturation: arguments 16'hFF00 (-1.0), 16'h0100, 16'h00FF -> result_data 8'h00, 8'hFF, 8'hFF respectively.
REQ-029 Backprop pass-through: train=1, argument 16'h0040, error 16'h0123 -> delta_data 16'h0123, delta_valid until delta_ready.
REQ-030 Backprop blocked: train=1, argument 16'h8000, error 16'h7FFF -> result 8'h00, delta_data 16'h0000.
REQ-031 Backpressure: hold result_ready low 5 cycles then high -> result_valid/result_data stable throughout, argument_ready low until handshake+1.
REQ-032 Reset mid-DEL: reset low with delta_valid high -> delta_valid low immediately, state ARG, argument_ready high after release.
